mvmul: RTL and testbench
========================

// Module: mvmul
// PURPOSE
// - Fixed-size matrix-vector multiplier: y = A * x over a shared 32-word x 32-bit RAM.
// - Sits beside a 2-read/1-write RAM with registered reads and a one-cycle-delayed write path.
// - Runs once after reset release, writes y back to RAM, then raises and holds valid.
// PARAMETERS
// - N       3   matrix dimension; A is NxN, x and y are N-vectors
// - DW      32  data width
// - AW      5   RAM address width
// - A_BASE  0   A stored row-major: A[r][c] at A_BASE + r*N + c
// - X_BASE  9   x[c] at X_BASE + c
// - Y_BASE  12  y[r] written to Y_BASE + r
// PORTS
// - clk      in   1   rising-edge clock
// - rst      in   1   reset; asynchronous, active-low (0 = in reset)
// - raddr_0  out  5   RAM read port 0 address (matrix element)
// - rdata_0  in   32  RAM read port 0 data; valid one cycle after raddr_0
// - raddr_1  out  5   RAM read port 1 address (vector element)
// - rdata_1  in   32  RAM read port 1 data; valid one cycle after raddr_1
// - waddr_0  out  5   RAM write address
// - wdata_0  out  32  RAM write data
// - wen_0    out  1   RAM write enable; RAM commits the write one clock after sampling
// - valid    out  1   high once all N results are committed
// BEHAVIOUR
// - While rst=0: raddr_0/raddr_1/waddr_0/wdata_0 = 0, wen_0 = 0, valid = 0.
// - FSM resets to IDLE.
// - Reset asserted mid-run: operation aborts immediately; a fresh run starts after release.
// - FSM states:
//   - IDLE: one cycle after release, go to LOAD with row=0, col=0, acc=0.
//   - LOAD: drive raddr_0 = A_BASE+row*N+col and raddr_1 = X_BASE+col.
//     - Increment col each cycle until col=N-1, then go to DRAIN.
//   - Accumulate: in each cycle after an address pair is issued, acc += rdata_0*rdata_1.
//     - Pipeline the issue flag through the delay sub-module to align it with the data.
//   - DRAIN: wait for the last product to be accumulated.
//   - WRITE: for one cycle drive wen_0=1, waddr_0 = Y_BASE+row, wdata_0 = acc.
//     - If row<N-1: row++, col=0, acc=0, back to LOAD.
//     - Otherwise go to FLUSH.
//   - FLUSH: wait 2 cycles to cover the RAM write delay, then go to DONE.
//   - DONE: valid=1, all strobes low, held until the next reset.
// - wen_0 is low in every state except WRITE; exactly N write pulses per run.
// - Arithmetic:
//   - 32x32 multiply truncated to the low 32 bits.
//   - Accumulation wraps modulo 2^32 (the result bits are the same for signed and unsigned operands).
//   - No saturation.
// - The block never reads Y_BASE..Y_BASE+N-1, so there is no read-after-write hazard.
// - Latency: valid rises no more than 40 cycles after reset release; N=3 takes about 20 cycles.
// STRUCTURE
// - Shared package: DW, AW, N, and the A_BASE/X_BASE/Y_BASE constants; FSM state enum.
// - Sub-module `delay`:
//   - parameter WIDTH (default 1); ports clk, in[WIDTH-1:0], out[WIDTH-1:0].
//   - out <= in on every rising clk edge; no reset; latency exactly 1 cycle.
//   - Used here for the read-issue flag.
//   - The RAM model uses the same sub-module for its wen/wdata/waddr delay, so it must exist standalone.
// TESTING
// - Nominal case:
//   - Preload mem[0..11] = 6,1,2,3,7,5,5,2,9,9,3,7, then release reset.
//   - Within 99 cycles, valid=1 and mem[12]=71, mem[13]=83, mem[14]=114.
// - Identity matrix:
//   - A = I, x = 4,5,6 -> y = 4,5,6.
//   - Check exactly 3 wen_0 pulses, at addresses 12, 13, 14.
// - Wrap-around:
//   - A[0][0] = 0xFFFFFFFF, x[0] = 2, other entries 0 -> mem[12] = 0xFFFFFFFE; mem[13], mem[14] = 0.
// - Reset mid-run:
//   - Drive rst=0 at cycle 5 of the run -> valid=0 and wen_0=0 immediately.
//   - After release the run completes with the nominal results.
// - Hold after completion:
//   - After valid rises, run 50 more cycles -> valid stays 1, no further wen_0 pulses, RAM unchanged.
// - delay unit:
//   - Drive in = 0xA5, 0x3C on consecutive edges -> out follows one cycle later.

Source files
------------

// File: rtl/mvmul_pkg.sv
// Shared constants, FSM state type and address helpers
// for the fixed-size matrix-vector multiplier.
package mvmul_pkg;

  localparam int N      = 3;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int A_BASE = 0;
  localparam int X_BASE = 9;
  localparam int Y_BASE = 12;
  localparam int CW     = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic [AW-1:0] a_addr(
    input logic [CW-1:0] r,
    input logic [CW-1:0] c
  );
    return AW'(A_BASE + int'(r) * N + int'(c));
  endfunction

  function automatic logic [AW-1:0] x_addr(
    input logic [CW-1:0] c
  );
    return AW'(X_BASE + int'(c));
  endfunction

  function automatic logic [AW-1:0] y_addr(
    input logic [CW-1:0] r
  );
    return AW'(Y_BASE + int'(r));
  endfunction

endpackage

// File: rtl/mvmul_delay.sv
// Single-cycle register delay without reset.
// Shared by the multiplier and the RAM write path.
module delay #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    out <= in;
  end

endmodule

// File: rtl/mvmul.sv
// y = A * x over a shared 2R/1W RAM; runs once after
// reset release, writes y back and then holds valid.
module mvmul
  import mvmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] raddr_0,
  input  logic [DW-1:0] rdata_0,
  output logic [AW-1:0] raddr_1,
  input  logic [DW-1:0] rdata_1,
  output logic [AW-1:0] waddr_0,
  output logic [DW-1:0] wdata_0,
  output logic          wen_0,
  output logic          valid
);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [DW-1:0] r_acc;
  logic          r_fcnt;
  logic          w_issue;
  logic          w_issue_d;
  logic          w_last_col;
  logic          w_last_row;
  logic [DW-1:0] w_prod;

  assign w_issue    = (r_state == S_LOAD);
  assign w_last_col = (r_col == CW'(N - 1));
  assign w_last_row = (r_row == CW'(N - 1));
  assign w_prod     = rdata_0 * rdata_1;

  // issue flag lines up with read data one cycle later
  delay #(.WIDTH(1)) u_issue (
    .clk (clk),
    .in  (w_issue),
    .out (w_issue_d)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = S_LOAD;
      S_LOAD:  if (w_last_col) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = w_last_row ? S_FLUSH : S_LOAD;
      S_FLUSH: if (r_fcnt) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    raddr_0 = '0;
    raddr_1 = '0;
    waddr_0 = '0;
    wdata_0 = '0;
    wen_0   = 1'b0;
    valid   = 1'b0;
    unique case (1'b1)
      (r_state == S_LOAD): begin
        raddr_0 = a_addr(r_row, r_col);
        raddr_1 = x_addr(r_col);
      end
      (r_state == S_WRITE): begin
        wen_0   = 1'b1;
        waddr_0 = y_addr(r_row);
        wdata_0 = r_acc;
      end
      (r_state == S_DONE): valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
      r_fcnt  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          r_row  <= '0;
          r_col  <= '0;
          r_acc  <= '0;
          r_fcnt <= 1'b0;
        end
        S_LOAD: begin
          if (!w_last_col) r_col <= r_col + 1'b1;
          if (w_issue_d) r_acc <= r_acc + w_prod;
        end
        S_DRAIN: begin
          if (w_issue_d) r_acc <= r_acc + w_prod;
        end
        S_WRITE: begin
          if (!w_last_row) r_row <= r_row + 1'b1;
          r_col <= '0;
          r_acc <= '0;
        end
        S_FLUSH: r_fcnt <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvmul.sv
// Self-checking bench for mvmul with a 2R/1W RAM model
// and a plain-arithmetic matrix-vector reference.
module tb_mvmul;
  import mvmul_pkg::*;

  logic          clk;
  logic          rst;
  logic [AW-1:0] raddr_0;
  logic [DW-1:0] rdata_0;
  logic [AW-1:0] raddr_1;
  logic [DW-1:0] rdata_1;
  logic [AW-1:0] waddr_0;
  logic [DW-1:0] wdata_0;
  logic          wen_0;
  logic          valid;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] ma [9];
  logic [DW-1:0] mx [3];
  logic [DW-1:0] my [3];

  logic [1+AW+DW-1:0] w_wr_d;
  logic [7:0]         d_in;
  logic [7:0]         d_out;

  int            n_checks;
  int            n_errors;
  int            wcnt;
  logic [AW-1:0] wq [$];

  mvmul dut (
    .clk     (clk),
    .rst     (rst),
    .raddr_0 (raddr_0),
    .rdata_0 (rdata_0),
    .raddr_1 (raddr_1),
    .rdata_1 (rdata_1),
    .waddr_0 (waddr_0),
    .wdata_0 (wdata_0),
    .wen_0   (wen_0),
    .valid   (valid)
  );

  delay #(.WIDTH(1 + AW + DW)) u_ram_wr (
    .clk (clk),
    .in  ({wen_0, waddr_0, wdata_0}),
    .out (w_wr_d)
  );

  delay #(.WIDTH(8)) u_dly (
    .clk (clk),
    .in  (d_in),
    .out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata_0 <= mem[raddr_0];
    rdata_1 <= mem[raddr_1];
    if (w_wr_d[AW+DW]) mem[w_wr_d[AW+DW-1:DW]] <= w_wr_d[DW-1:0];
  end

  always @(posedge clk) begin
    if (wen_0) begin
      wcnt = wcnt + 1;
      wq.push_back(waddr_0);
    end
  end

  task automatic model();
    logic [DW-1:0] acc;
    for (int r = 0; r < 3; r++) begin
      acc = '0;
      for (int c = 0; c < 3; c++) acc = acc + ma[r*3+c] * mx[c];
      my[r] = acc;
    end
  endtask

  task automatic set_nominal();
    logic [DW-1:0] v [12];
    v = '{6, 1, 2, 3, 7, 5, 5, 2, 9, 9, 3, 7};
    for (int i = 0; i < 9; i++) ma[i] = v[i];
    for (int i = 0; i < 3; i++) mx[i] = v[9+i];
  endtask

  task automatic do_run();
    int cyc;
    bit ok;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 9; i++) mem[A_BASE+i] = ma[i];
    for (int i = 0; i < 3; i++) mem[X_BASE+i] = mx[i];
    for (int i = 0; i < 3; i++) mem[Y_BASE+i] = 32'hDEAD_0000 + i;
    wcnt = 0;
    wq.delete();
    model();
    rst = 1'b1;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 99 && !ok) begin
      @(negedge clk);
      cyc++;
      if (valid) ok = 1'b1;
    end
    n_checks++;
    if (!ok || cyc > 40) begin
      n_errors++;
      $display("FAIL run_latency: cycles=%0d valid=%0b required<=40", cyc, valid);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    d_in = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({raddr_0, raddr_1, waddr_0, wdata_0, wen_0, valid} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ra0=%0h ra1=%0h wa=%0h wd=%0h wen=%0b valid=%0b required all 0",
               raddr_0, raddr_1, waddr_0, wdata_0, wen_0, valid);
    end
  endtask

  task automatic test_nominal();
    logic [DW-1:0] exp [3];
    exp = '{71, 83, 114};
    set_nominal();
    do_run();
    for (int r = 0; r < 3; r++) begin
      n_checks++;
      if (mem[Y_BASE+r] !== exp[r] || my[r] !== exp[r]) begin
        n_errors++;
        $display("FAIL nominal_y%0d: got %0d model %0d required %0d",
                 r, mem[Y_BASE+r], my[r], exp[r]);
      end
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 9; i++) ma[i] = (i % 4 == 0) ? 32'd1 : 32'd0;
    mx = '{4, 5, 6};
    do_run();
    for (int r = 0; r < 3; r++) begin
      n_checks++;
      if (mem[Y_BASE+r] !== mx[r]) begin
        n_errors++;
        $display("FAIL identity_y%0d: got %0d required %0d", r, mem[Y_BASE+r], mx[r]);
      end
    end
    n_checks++;
    if (wcnt !== 3) begin
      n_errors++;
      $display("FAIL identity_wen_count: got %0d required 3", wcnt);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= wq.size() || wq[i] !== AW'(Y_BASE + i)) begin
        n_errors++;
        $display("FAIL identity_waddr%0d: got %0d required %0d",
                 i, (i < wq.size()) ? wq[i] : '1, Y_BASE + i);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) ma[i] = '0;
    ma[0] = 32'hFFFF_FFFF;
    mx    = '{2, 0, 0};
    do_run();
    n_checks++;
    if (mem[Y_BASE] !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL wrap_y0: got %0h required fffffffe", mem[Y_BASE]);
    end
    for (int r = 1; r < 3; r++) begin
      n_checks++;
      if (mem[Y_BASE+r] !== '0) begin
        n_errors++;
        $display("FAIL wrap_y%0d: got %0h required 0", r, mem[Y_BASE+r]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 9; i++)
        ma[i] = (t[0]) ? $urandom : $urandom_range(0, 1000);
      for (int i = 0; i < 3; i++)
        mx[i] = (t[0]) ? $urandom : $urandom_range(0, 1000);
      do_run();
      for (int r = 0; r < 3; r++) begin
        n_checks++;
        if (mem[Y_BASE+r] !== my[r]) begin
          n_errors++;
          $display("FAIL random%0d_y%0d: got %0h required %0h",
                   t, r, mem[Y_BASE+r], my[r]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_nominal();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) mem[A_BASE+i] = ma[i];
    for (int i = 0; i < 3; i++) mem[X_BASE+i] = mx[i];
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0 || wen_0 !== 1'b0 || raddr_0 !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: valid=%0b wen=%0b ra0=%0h required 0",
               valid, wen_0, raddr_0);
    end
    do_run();
    for (int r = 0; r < 3; r++) begin
      n_checks++;
      if (mem[Y_BASE+r] !== my[r]) begin
        n_errors++;
        $display("FAIL midreset_y%0d: got %0d required %0d", r, mem[Y_BASE+r], my[r]);
      end
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] snap [32];
    int            bad;
    for (int i = 0; i < 32; i++) snap[i] = mem[i];
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (valid !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL hold_valid: low for %0d cycles required 0", bad);
    end
    n_checks++;
    if (wcnt !== 3) begin
      n_errors++;
      $display("FAIL hold_wen_count: got %0d required 3", wcnt);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== snap[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL hold_ram: %0d words changed required 0", bad);
    end
  endtask

  task automatic test_delay();
    @(negedge clk);
    d_in = 8'hA5;
    @(negedge clk);
    d_in = 8'h3C;
    #1;
    n_checks++;
    if (d_out !== 8'hA5) begin
      n_errors++;
      $display("FAIL delay_a5: got %0h required a5", d_out);
    end
    @(negedge clk);
    n_checks++;
    if (d_out !== 8'h3C) begin
      n_errors++;
      $display("FAIL delay_3c: got %0h required 3c", d_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wcnt     = 0;
    test_reset();
    test_nominal();
    test_hold();
    test_identity();
    test_wrap();
    test_random();
    test_reset_mid();
    test_delay();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
